// File: rtl/mole_pkg.sv
// Shared definitions for the Whac-A-Mole sequencer: state encodings, BCD limits
// and the two-digit BCD up/down step function.
package mole_pkg;

  localparam logic [4:0] ST_IDLE  = 5'd0;
  localparam logic [4:0] ST_DELAY = 5'd2;
  localparam logic [4:0] ST_PLAY  = 5'd3;
  localparam logic [4:0] ST_OVER  = 5'd4;

  localparam logic [7:0] BCD_ZERO = 8'h00;
  localparam logic [7:0] BCD_MAX  = 8'h99;

  typedef enum logic [4:0] {
    S_IDLE  = ST_IDLE,
    S_DELAY = ST_DELAY,
    S_PLAY  = ST_PLAY,
    S_OVER  = ST_OVER
  } state_e;

  // Up and down together cancel; saturates at 00 and 99.
  function automatic logic [7:0] bcd2_step(input logic [7:0] v,
                                           input logic       up,
                                           input logic       dn);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (up && !dn && (v != BCD_MAX)) begin
      if (lo == 4'd9) begin
        lo = 4'd0;
        hi = hi + 4'd1;
      end else begin
        lo = lo + 4'd1;
      end
    end else if (dn && !up && (v != BCD_ZERO)) begin
      if (lo == 4'd0) begin
        lo = 4'd9;
        hi = hi - 4'd1;
      end else begin
        lo = lo - 4'd1;
      end
    end
    return {hi, lo};
  endfunction

endpackage

// File: rtl/mole_game_ctrl_if.sv
// Control/status bundle between the game sequencer and its surroundings.
// Optional level input pause exists only when MOLE_PAUSE_EN is defined.
interface mole_game_ctrl_if;
  logic        start;
  logic        hit;
  logic        miss;
`ifdef MOLE_PAUSE_EN
  logic        pause;
`endif
  logic [4:0]  state;
  logic [15:0] delay;
  logic [7:0]  resttime;
  logic [7:0]  score;
  logic        timeover;
  logic        scorezero;
  logic        tick;

  modport master (
`ifdef MOLE_PAUSE_EN
    output pause,
`endif
    output start, hit, miss,
    input  state, delay, resttime, score, timeover, scorezero, tick
  );

  modport slave (
`ifdef MOLE_PAUSE_EN
    input  pause,
`endif
    input  start, hit, miss,
    output state, delay, resttime, score, timeover, scorezero, tick
  );
endinterface

// File: rtl/mole_game_ctrl_bcd2_updown.sv
// Two-digit BCD up/down next-value stage with saturation at 00 and 99.
module bcd2_updown
  import mole_pkg::*;
(
  input  logic [7:0] val,
  input  logic       up,
  input  logic       down,
  output logic [7:0] nxt
);
  always_comb begin
    nxt = bcd2_step(val, up, down);
  end
endmodule

// File: rtl/mole_game_ctrl.sv
// Whac-A-Mole game sequencer: 1 s tick, IDLE/DELAY/PLAY/OVER FSM, countdowns, score.
// Define MOLE_PAUSE_EN to add the pause input that freezes timers in DELAY/PLAY.
module mole_game_ctrl
  import mole_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter logic [7:0]  GAME_SECS  = 8'h60,
  parameter logic [7:0]  DELAY_SECS = 8'h03
) (
  input  logic              clk,
  input  logic              rst,
  mole_game_ctrl_if.slave   bus
);
  localparam int unsigned     DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       dly_q, dly_d;
  logic [7:0]       rest_q, rest_d;
  logic [7:0]       score_q, score_d;
  logic             tick_q, tick_d;
  logic             timeover_q, timeover_d;
  logic             scorezero_q, scorezero_d;

  logic             paused;
  logic             wrap;
  logic             restart;
  logic [7:0]       score_nxt, rest_nxt, dly_nxt;

`ifdef MOLE_PAUSE_EN
  assign paused = bus.pause && ((state_q == S_DELAY) || (state_q == S_PLAY));
`else
  assign paused = 1'b0;
`endif

  assign wrap = (div_q == DIV_LAST) && !paused;

  bcd2_updown u_score (
    .val  (score_q),
    .up   (bus.hit  && !paused),
    .down (bus.miss && !paused),
    .nxt  (score_nxt)
  );

  bcd2_updown u_rest (
    .val  (rest_q),
    .up   (1'b0),
    .down (1'b1),
    .nxt  (rest_nxt)
  );

  bcd2_updown u_dly (
    .val  (dly_q),
    .up   (1'b0),
    .down (1'b1),
    .nxt  (dly_nxt)
  );

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    rest_d  = rest_q;
    score_d = score_q;
    restart = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) restart = 1'b1;
      end
      S_DELAY: begin
        if (bus.start) begin
          restart = 1'b1;
        end else if (wrap) begin
          dly_d = dly_nxt;
          if (dly_q == 8'h01) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (bus.start) begin
          restart = 1'b1;
        end else begin
          // Score step and final tick share a cycle so a last-moment hit still counts.
          score_d = score_nxt;
          if (wrap) begin
            rest_d = rest_nxt;
            if (rest_q == 8'h01) state_d = S_OVER;
          end
        end
      end
      S_OVER: begin
        if (bus.start) restart = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d = S_DELAY;
      dly_d   = DELAY_SECS;
      rest_d  = GAME_SECS;
      score_d = BCD_ZERO;
    end

    // Clearing on every transition keeps the first tick of a state exactly TICK_DIV away.
    if (restart || (state_d != state_q) || wrap) begin
      div_d = '0;
    end else if (paused) begin
      div_d = div_q;
    end else begin
      div_d = div_q + 1'b1;
    end

    tick_d      = wrap;
    timeover_d  = (state_d == S_OVER);
    scorezero_d = (score_d == BCD_ZERO) && ((state_d == S_PLAY) || (state_d == S_OVER));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      dly_q       <= BCD_ZERO;
      rest_q      <= GAME_SECS;
      score_q     <= BCD_ZERO;
      tick_q      <= 1'b0;
      timeover_q  <= 1'b0;
      scorezero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      dly_q       <= dly_d;
      rest_q      <= rest_d;
      score_q     <= score_d;
      tick_q      <= tick_d;
      timeover_q  <= timeover_d;
      scorezero_q <= scorezero_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.delay     = {8'h00, dly_q};
  assign bus.resttime  = rest_q;
  assign bus.score     = score_q;
  assign bus.timeover  = timeover_q;
  assign bus.scorezero = scorezero_q;
  assign bus.tick      = tick_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed self-checking bench for mole_game_ctrl (TICK_DIV=4, default game/delay lengths).
module tb_mole_game_ctrl;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mole_game_ctrl_if bus();

  mole_game_ctrl #(
    .TICK_DIV   (4),
    .GAME_SECS  (8'h60),
    .DELAY_SECS (8'h03)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic go_play();
    pulse_start();
    repeat (12) cyc();
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    checks++; if (bus.state !== 5'd0) begin errors++; $display("FAIL rst_state got %0d want 0", bus.state); end
    checks++; if (bus.delay !== 16'h0000) begin errors++; $display("FAIL rst_delay got %h want 0000", bus.delay); end
    checks++; if (bus.resttime !== 8'h60) begin errors++; $display("FAIL rst_rest got %h want 60", bus.resttime); end
    checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL rst_score got %h want 00", bus.score); end
    checks++; if ({bus.timeover, bus.scorezero, bus.tick} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {bus.timeover, bus.scorezero, bus.tick}); end
    rst = 1'b0;
    bus.hit = 1'b1;
    cyc();
    bus.hit = 1'b0;
    checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL idle_hit score got %h want 00", bus.score); end
    go_play();
    checks++; if (bus.state !== 5'd3) begin errors++; $display("FAIL reach_play got %0d want 3", bus.state); end
    bus.hit = 1'b1;
    repeat (3) cyc();
    bus.hit = 1'b0;
    checks++; if (bus.score !== 8'h03) begin errors++; $display("FAIL play_hits got %h want 03", bus.score); end
    rst = 1'b1;
    cyc();
    checks++; if (bus.state !== 5'd0) begin errors++; $display("FAIL midrst_state got %0d want 0", bus.state); end
    checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL midrst_score got %h want 00", bus.score); end
    checks++; if (bus.resttime !== 8'h60) begin errors++; $display("FAIL midrst_rest got %h want 60", bus.resttime); end
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL midrst_tick got %b want 0", bus.tick); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_countdown();
    logic [15:0] exp_dly [1:3];
    logic [4:0]  exp_st  [1:3];
    exp_dly[1] = 16'h0002; exp_st[1] = 5'd2;
    exp_dly[2] = 16'h0001; exp_st[2] = 5'd2;
    exp_dly[3] = 16'h0000; exp_st[3] = 5'd3;
    pulse_start();
    checks++; if (bus.state !== 5'd2) begin errors++; $display("FAIL cd_enter state got %0d want 2", bus.state); end
    checks++; if (bus.delay !== 16'h0003) begin errors++; $display("FAIL cd_enter delay got %h want 0003", bus.delay); end
    bus.hit  = 1'b1;
    bus.miss = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      repeat (3) cyc();
      checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL cd_pretick%0d got %b want 0", k, bus.tick); end
      cyc();
      checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL cd_tick%0d got %b want 1", k, bus.tick); end
      checks++; if (bus.delay !== exp_dly[k]) begin errors++; $display("FAIL cd_delay%0d got %h want %h", k, bus.delay, exp_dly[k]); end
      checks++; if (bus.state !== exp_st[k]) begin errors++; $display("FAIL cd_state%0d got %0d want %0d", k, bus.state, exp_st[k]); end
    end
    bus.hit = 1'b0;
    checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL delay_hit score got %h want 00", bus.score); end
    checks++; if (bus.scorezero !== 1'b1) begin errors++; $display("FAIL play_zero got %b want 1", bus.scorezero); end
  endtask

  task automatic test_delay_restart();
    pulse_start();
    checks++; if (bus.state !== 5'd2) begin errors++; $display("FAIL rs_play state got %0d want 2", bus.state); end
    repeat (6) cyc();
    checks++; if (bus.delay !== 16'h0002) begin errors++; $display("FAIL rs_mid delay got %h want 0002", bus.delay); end
    pulse_start();
    checks++; if (bus.delay !== 16'h0003) begin errors++; $display("FAIL rs_reload delay got %h want 0003", bus.delay); end
    repeat (3) cyc();
    checks++; if (bus.delay !== 16'h0003) begin errors++; $display("FAIL rs_divclr delay got %h want 0003", bus.delay); end
    cyc();
    checks++; if (bus.delay !== 16'h0002) begin errors++; $display("FAIL rs_tick delay got %h want 0002", bus.delay); end
  endtask

  task automatic test_saturation();
    go_play();
    bus.hit = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      checks++; if (bus.score[3:0] > 4'd9 || bus.score[7:4] > 4'd9) begin errors++; $display("FAIL sat_digit%0d got %h want BCD", i, bus.score); end
    end
    bus.hit = 1'b0;
    checks++; if (bus.score !== 8'h99) begin errors++; $display("FAIL sat_hi got %h want 99", bus.score); end
    bus.hit = 1'b1; bus.miss = 1'b1;
    cyc();
    bus.hit = 1'b0;
    checks++; if (bus.score !== 8'h99) begin errors++; $display("FAIL both_hi got %h want 99", bus.score); end
    for (int i = 0; i < 100; i++) cyc();
    bus.miss = 1'b0;
    checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL sat_lo got %h want 00", bus.score); end
    checks++; if (bus.scorezero !== 1'b1) begin errors++; $display("FAIL sat_zero got %b want 1", bus.scorezero); end
    bus.hit = 1'b1; bus.miss = 1'b1;
    cyc();
    bus.hit = 1'b0; bus.miss = 1'b0;
    checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL both_lo got %h want 00", bus.score); end
    checks++; if (bus.state !== 5'd3) begin errors++; $display("FAIL sat_state got %0d want 3", bus.state); end
  endtask

  task automatic test_restart();
    go_play();
    bus.hit = 1'b1;
    repeat (42) cyc();
    bus.hit = 1'b0;
    checks++; if (bus.score !== 8'h42) begin errors++; $display("FAIL rst42 score got %h want 42", bus.score); end
    pulse_start();
    checks++; if (bus.state !== 5'd2) begin errors++; $display("FAIL rst42 state got %0d want 2", bus.state); end
    checks++; if (bus.delay !== 16'h0003) begin errors++; $display("FAIL rst42 delay got %h want 0003", bus.delay); end
    checks++; if (bus.score !== 8'h00) begin errors++; $display("FAIL rst42 clear got %h want 00", bus.score); end
    checks++; if (bus.resttime !== 8'h60) begin errors++; $display("FAIL rst42 rest got %h want 60", bus.resttime); end
    checks++; if (bus.scorezero !== 1'b0) begin errors++; $display("FAIL rst42 zero got %b want 0", bus.scorezero); end
  endtask

  task automatic test_game_end();
    go_play();
    for (int n = 59; n >= 0; n--) begin
      for (int c = 0; c < 4; c++) begin
        bus.hit = ((n == 59) && (c == 0)) || ((n == 0) && (c == 3));
        cyc();
      end
      bus.hit = 1'b0;
      checks++; if (bus.resttime !== to_bcd(n)) begin errors++; $display("FAIL rest_%0d got %h want %h", n, bus.resttime, to_bcd(n)); end
      checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL tick_%0d got %b want 1", n, bus.tick); end
    end
    checks++; if (bus.state !== 5'd4) begin errors++; $display("FAIL end_state got %0d want 4", bus.state); end
    checks++; if (bus.timeover !== 1'b1) begin errors++; $display("FAIL end_timeover got %b want 1", bus.timeover); end
    checks++; if (bus.score !== 8'h02) begin errors++; $display("FAIL end_lasthit got %h want 02", bus.score); end
    for (int i = 0; i < 3; i++) begin
      bus.hit = 1'b1; cyc(); bus.hit = 1'b0; cyc();
      bus.miss = 1'b1; cyc(); bus.miss = 1'b0;
    end
    repeat (8) cyc();
    checks++; if (bus.score !== 8'h02) begin errors++; $display("FAIL over_hold score got %h want 02", bus.score); end
    checks++; if (bus.resttime !== 8'h00) begin errors++; $display("FAIL over_hold rest got %h want 00", bus.resttime); end
    checks++; if (bus.state !== 5'd4) begin errors++; $display("FAIL over_hold state got %0d want 4", bus.state); end
    checks++; if (bus.scorezero !== 1'b0) begin errors++; $display("FAIL over_zero got %b want 0", bus.scorezero); end
  endtask

`ifdef MOLE_PAUSE_EN
  task automatic test_pause();
    go_play();
    repeat (4) cyc();
    checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL pz_pre tick got %b want 1", bus.tick); end
    bus.pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.hit = (i % 2 == 0);
      cyc();
      checks++; if (bus.tick !== 1'b0 || bus.resttime !== 8'h59 || bus.score !== 8'h00 || bus.state !== 5'd3) begin
        errors++; $display("FAIL pz_hold%0d got tick=%b rest=%h score=%h state=%0d want 0/59/00/3", i, bus.tick, bus.resttime, bus.score, bus.state);
      end
    end
    bus.hit   = 1'b0;
    bus.pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL pz_rel%0d tick got %b want 0", i, bus.tick); end
    end
    cyc();
    checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL pz_tick got %b want 1", bus.tick); end
    checks++; if (bus.resttime !== 8'h58) begin errors++; $display("FAIL pz_rest got %h want 58", bus.resttime); end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    bus.miss  = 1'b0;
`ifdef MOLE_PAUSE_EN
    bus.pause = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_countdown();
    test_delay_restart();
    test_saturation();
    test_restart();
    test_game_end();
`ifdef MOLE_PAUSE_EN
    test_pause();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
